// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One operation in flight: IDLE grants and issues, EXEC samples the ALU, RESP holds the response.
module alu_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [2:0]        op0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              req1,
  input  logic [2:0]        op1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic [2:0]        flags,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  output logic [2:0]        alu_operation,
  output logic [2:0]        alu_flags_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [2:0]        alu_flags_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_id_q, rsp_id_d;
  logic                rsp_err_q, rsp_err_d;
  logic [2:0]          flags_q, flags_d;
  logic                gnt0_c, gnt1_c;
  logic                res_zero;

  assign res_zero = (alu_result == {DATA_W{1'b0}});

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      op_q         <= 3'b000;
      a_q          <= {DATA_W{1'b0}};
      b_q          <= {DATA_W{1'b0}};
      id_q         <= 1'b0;
      rsp_result_q <= {DATA_W{1'b0}};
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      flags_q      <= 3'b000;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      flags_q      <= flags_d;
    end
  end

  // Round-robin grant; last_q names the requester granted most recently
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0 && req1) begin
        if (last_q) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
      end else if (req0) begin
        gnt0_c = 1'b1;
      end else if (req1) begin
        gnt1_c = 1'b1;
      end else begin
        gnt0_c = 1'b0;
      end
    end else begin
      gnt0_c = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0_c || gnt1_c) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue capture on grant, response and flag update at the end of EXEC
  always_comb begin
    last_d       = last_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    flags_d      = flags_q;
    if (gnt0_c) begin
      op_d   = op0;
      a_d    = a0;
      b_d    = b0;
      id_d   = 1'b0;
      last_d = 1'b0;
    end else if (gnt1_c) begin
      op_d   = op1;
      a_d    = a1;
      b_d    = b1;
      id_d   = 1'b1;
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
    if (state_q == ST_EXEC) begin
      rsp_id_d  = id_q;
      rsp_err_d = 1'b0;
      case (op_q)
        3'b000: begin
          rsp_result_d = alu_result;
          flags_d      = {alu_result[DATA_W-1], res_zero, alu_flags_out[0]};
        end
        3'b001: begin
          rsp_result_d = {DATA_W{1'b0}};
          flags_d      = {flags_q[2:1], 1'b1};
        end
        3'b010, 3'b011, 3'b100, 3'b101, 3'b110: begin
          rsp_result_d = alu_result;
          flags_d      = {alu_result[DATA_W-1], res_zero, flags_q[0]};
        end
        default: begin
          // Illegal opcode: ALU output is discarded and flags are left alone
          rsp_result_d = {DATA_W{1'b0}};
          rsp_err_d    = 1'b1;
          flags_d      = flags_q;
        end
      endcase
    end else begin
      rsp_id_d = rsp_id_q;
    end
  end

  // Output decode
  always_comb begin
    gnt0          = gnt0_c;
    gnt1          = gnt1_c;
    rsp_valid     = (state_q == ST_RESP);
    rsp_id        = rsp_id_q;
    rsp_result    = rsp_result_q;
    rsp_err       = rsp_err_q;
    flags         = flags_q;
    alu_operand1  = a_q;
    alu_operand2  = b_q;
    alu_operation = op_q;
    alu_flags_in  = flags_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the ALU-side ports.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_result;
  logic [2:0]  flags;
  logic [15:0] alu_operand1, alu_operand2;
  logic [2:0]  alu_operation, alu_flags_in;
  logic [15:0] alu_result;
  logic [2:0]  alu_flags_out;
  logic        alu_c;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .flags(flags),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_operation(alu_operation), .alu_flags_in(alu_flags_in),
    .alu_result(alu_result), .alu_flags_out(alu_flags_out)
  );

  always #5 clk = ~clk;

  // Reference ALU; opcodes the arbiter must ignore return a marker value
  always_comb begin
    alu_c      = 1'b0;
    alu_result = 16'h0000;
    case (alu_operation)
      3'b000:  {alu_c, alu_result} = {1'b0, alu_operand1} + {1'b0, alu_operand2};
      3'b010:  alu_result = alu_operand1 - alu_operand2;
      3'b011:  alu_result = alu_operand1 & alu_operand2;
      3'b100:  alu_result = alu_operand1 | alu_operand2;
      3'b101:  alu_result = alu_operand1 ^ alu_operand2;
      3'b110:  alu_result = alu_operand1 << 1;
      default: alu_result = 16'hDEAD;
    endcase
    alu_flags_out = {2'b11, alu_c};
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from one requester and check grant, latency and response
  task automatic run_op(input logic who, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic [2:0] exp_flags, input logic exp_err);
    bit got;
    got = 1'b0;
    if (who) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    for (int i = 0; i < 8; i++) begin
      #1;
      if ((who ? gnt1 : gnt0) === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check_val("gnt_seen", {31'd0, got}, 32'd1);
    check_val("gnt_other", {31'd0, (who ? gnt0 : gnt1)}, 32'd0);
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    check_val("exec_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("exec_op", {29'd0, alu_operation}, {29'd0, op});
    check_val("exec_a", {16'd0, alu_operand1}, {16'd0, a});
    tick();
    check_val("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("rsp_result", {16'd0, rsp_result}, {16'd0, exp_res});
    check_val("rsp_id", {31'd0, rsp_id}, {31'd0, who});
    check_val("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check_val("flags", {29'd0, flags}, {29'd0, exp_flags});
    check_val("flags_in", {29'd0, alu_flags_in}, {29'd0, exp_flags});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("rsp_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_val({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 32'd0);
    check_val({tag, "_id"}, {31'd0, rsp_id}, 32'd0);
    check_val({tag, "_res"}, {16'd0, rsp_result}, 32'd0);
    check_val({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    check_val({tag, "_flags"}, {29'd0, flags}, 32'd0);
    check_val({tag, "_aluop"}, {29'd0, alu_operation}, 32'd0);
    check_val({tag, "_opnd"}, {alu_operand1, alu_operand2}, 32'd0);
  endtask

  logic [1:0] exp_gnt [10];

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
    op0 = 3'b000; op1 = 3'b000; a0 = 16'h0; b0 = 16'h0; a1 = 16'h0; b1 = 16'h0;
    tick();
    tick();
    check_reset_state("rst");
    rst_n = 1'b1;
    tick();

    run_op(1'b0, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b011, 1'b0);
    run_op(1'b1, 3'b001, 16'h1234, 16'h5678, 16'h0000, 3'b011, 1'b0);
    run_op(1'b0, 3'b010, 16'h0003, 16'h0005, 16'hFFFE, 3'b101, 1'b0);
    run_op(1'b1, 3'b111, 16'h1234, 16'h0001, 16'h0000, 3'b101, 1'b1);
    run_op(1'b0, 3'b011, 16'hF0F0, 16'h0F0F, 16'h0000, 3'b011, 1'b0);
    run_op(1'b1, 3'b100, 16'h8000, 16'h0001, 16'h8001, 3'b101, 1'b0);
    run_op(1'b0, 3'b101, 16'hAAAA, 16'hAAAA, 16'h0000, 3'b011, 1'b0);
    run_op(1'b1, 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1'b0);
    run_op(1'b0, 3'b110, 16'h4001, 16'h0000, 16'h8002, 3'b100, 1'b0);

    // Backpressure: req1 waits while the response sits unaccepted
    req0 = 1'b1; op0 = 3'b000; a0 = 16'h0001; b0 = 16'h0002;
    #1;
    check_val("bp_gnt0", {31'd0, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    req1 = 1'b1; op1 = 3'b000; a1 = 16'h0005; b1 = 16'h0005;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_val("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("bp_res", {16'd0, rsp_result}, 32'h0000_0003);
      check_val("bp_gnt1", {31'd0, gnt1}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_val("bp_gnt1_acc", {31'd0, gnt1}, 32'd0);
    tick();
    rsp_ready = 1'b0;
    check_val("bp_gnt1_after", {31'd0, gnt1}, 32'd1);
    check_val("bp_valid_after", {31'd0, rsp_valid}, 32'd0);
    tick();
    req1 = 1'b0;
    tick();
    check_val("bp2_res", {16'd0, rsp_result}, 32'h0000_000A);
    check_val("bp2_id", {31'd0, rsp_id}, 32'd1);
    check_val("bp2_flags", {29'd0, flags}, 32'd0);
    rsp_ready = 1'b1;
    tick();

    // Fresh reset, then both requesters tie continuously: 0, 1, 0, 1 every 3 cycles
    rst_n = 1'b0; rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("rst2");
    req0 = 1'b1; op0 = 3'b011; a0 = 16'h0000; b0 = 16'h0000;
    req1 = 1'b1; op1 = 3'b011; a1 = 16'h0000; b1 = 16'h0000;
    rsp_ready = 1'b1;
    exp_gnt = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    for (int i = 0; i < 10; i++) begin
      #1;
      check_val($sformatf("rr_%0d", i), {30'd0, gnt1, gnt0}, {30'd0, exp_gnt[i]});
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    check_val("rr_flags", {29'd0, flags}, 32'h0000_0002);
    rsp_ready = 1'b0;

    // Reset during EXEC abandons the operation
    run_op(1'b0, 3'b001, 16'h0000, 16'h0000, 16'h0000, 3'b011, 1'b0);
    req0 = 1'b1; op0 = 3'b000; a0 = 16'hFFFF; b0 = 16'h0001;
    #1;
    check_val("ex_gnt0", {31'd0, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("rst_exec");
    tick();
    check_val("rst_exec_novalid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_val("rst_exec_novalid2", {31'd0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
